// File: rtl/aes_pkg.sv
// Shared definitions for the AES request scheduler: datapath width,
// FSM state encoding and the default watchdog limit.
package aes_pkg;

    localparam int AES_W       = 128;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/aes_req_sched_if.sv
// Bundle of request, response and AES-core signals around the scheduler.
// The slave modport is the scheduler's view; master is the environment's view.
interface aes_req_sched_if
    import aes_pkg::*;
#(
    parameter int NUM_REQ = 2
);

    logic [NUM_REQ-1:0]       iReqVld;
    logic [NUM_REQ-1:0]       oReqRdy;
    logic [AES_W*NUM_REQ-1:0] iReqKey;
    logic [AES_W*NUM_REQ-1:0] iReqPText;
    logic [NUM_REQ-1:0]       oRspVld;
    logic [NUM_REQ-1:0]       iRspRdy;
    logic [AES_W-1:0]         oRspData;
    logic                     oRspErr;
    logic                     oStAes;
    logic [AES_W-1:0]         oAesKey;
    logic [AES_W-1:0]         oPlainText;
    logic                     iAesDone;
    logic [AES_W-1:0]         iCpText;
    logic                     oBusy;

    modport slave (
        input  iReqVld, iReqKey, iReqPText, iRspRdy, iAesDone, iCpText,
        output oReqRdy, oRspVld, oRspData, oRspErr, oStAes, oAesKey, oPlainText, oBusy
    );

    modport master (
        output iReqVld, iReqKey, iReqPText, iRspRdy, iAesDone, iCpText,
        input  oReqRdy, oRspVld, oRspData, oRspErr, oStAes, oAesKey, oPlainText, oBusy
    );

endinterface

// File: rtl/aes_rr_arb.sv
// Combinational round-robin arbiter: searches the request vector starting one
// position after ptr (with wrap-around) and returns a one-hot grant and its index.
module aes_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grantIdx,
    output logic               anyGrant
);

    // candIdx[k] is the requester examined at search step k
    logic [IDX_W-1:0] candIdx [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : gCand
            assign candIdx[gi] = IDX_W'((int'(ptr) + 1 + gi) % NUM_REQ);
        end
    endgenerate

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        anyGrant = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!anyGrant && req[candIdx[k]]) begin
                anyGrant = 1'b1;
                grantIdx = candIdx[k];
            end
        end
        grant[grantIdx] = anyGrant;
    end

endmodule

// File: rtl/aes_req_sched.sv
// Shares one AES-128 core among NUM_REQ requesters: round-robin accept, one-cycle
// start pulse, ciphertext capture on done, per-requester response and a watchdog.
module aes_req_sched
    import aes_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 8
) (
    input  logic            iClk,
    input  logic            iRst,
    aes_req_sched_if.slave  bus
);

    localparam int               IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    state_t           stateReg, stateNext;
    logic [IDX_W-1:0] ptrReg, ptrNext;
    logic [IDX_W-1:0] idReg, idNext;
    logic [AES_W-1:0] keyReg, keyNext;
    logic [AES_W-1:0] ptxtReg, ptxtNext;
    logic [AES_W-1:0] rspDataReg, rspDataNext;
    logic             rspErrReg, rspErrNext;
    logic [CNT_W-1:0] wdReg, wdNext;

    logic [NUM_REQ-1:0] arbGrant;
    logic [IDX_W-1:0]   arbIdx;
    logic               arbAny;
    logic [NUM_REQ-1:0] idOneHot;
    logic               ownRspRdy;
    logic [AES_W-1:0]   reqKey  [NUM_REQ];
    logic [AES_W-1:0]   reqPText[NUM_REQ];

    aes_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) uArb (
        .req      (bus.iReqVld),
        .ptr      (ptrReg),
        .grant    (arbGrant),
        .grantIdx (arbIdx),
        .anyGrant (arbAny)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : gReq
            assign reqKey[gi]   = bus.iReqKey[gi*AES_W +: AES_W];
            assign reqPText[gi] = bus.iReqPText[gi*AES_W +: AES_W];
            assign idOneHot[gi] = (idReg == IDX_W'(gi));
        end
    endgenerate

    // Only the owning requester's ready can complete the response
    assign ownRspRdy = |(bus.iRspRdy & idOneHot);

    assign bus.oReqRdy    = (stateReg == ST_IDLE) ? arbGrant : '0;
    assign bus.oRspVld    = (stateReg == ST_RESP) ? idOneHot : '0;
    assign bus.oRspData   = rspDataReg;
    assign bus.oRspErr    = rspErrReg;
    assign bus.oStAes     = (stateReg == ST_LAUNCH);
    assign bus.oAesKey    = keyReg;
    assign bus.oPlainText = ptxtReg;
    assign bus.oBusy      = (stateReg != ST_IDLE);

    always_comb begin
        stateNext   = stateReg;
        ptrNext     = ptrReg;
        idNext      = idReg;
        keyNext     = keyReg;
        ptxtNext    = ptxtReg;
        rspDataNext = rspDataReg;
        rspErrNext  = rspErrReg;
        wdNext      = wdReg;
        case (stateReg)
            ST_IDLE: begin
                // A grant implies valid and ready for the same requester
                if (arbAny) begin
                    keyNext   = reqKey[arbIdx];
                    ptxtNext  = reqPText[arbIdx];
                    idNext    = arbIdx;
                    ptrNext   = arbIdx;
                    stateNext = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                wdNext    = '0;
                stateNext = ST_BUSY;
            end
            ST_BUSY: begin
                wdNext = wdReg + CNT_W'(1);
                if (bus.iAesDone) begin
                    rspDataNext = bus.iCpText;
                    rspErrNext  = 1'b0;
                    stateNext   = ST_RESP;
                end else if (wdReg == WD_LAST) begin
                    rspDataNext = '0;
                    rspErrNext  = 1'b1;
                    stateNext   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (ownRspRdy) begin
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            stateReg   <= ST_IDLE;
            ptrReg     <= IDX_W'(NUM_REQ - 1);
            idReg      <= '0;
            keyReg     <= '0;
            ptxtReg    <= '0;
            rspDataReg <= '0;
            rspErrReg  <= 1'b0;
            wdReg      <= '0;
        end else begin
            stateReg   <= stateNext;
            ptrReg     <= ptrNext;
            idReg      <= idNext;
            keyReg     <= keyNext;
            ptxtReg    <= ptxtNext;
            rspDataReg <= rspDataNext;
            rspErrReg  <= rspErrNext;
            wdReg      <= wdNext;
        end
    end

endmodule

// File: tb/tb_aes_req_sched.sv
// Directed bench for aes_req_sched with two requesters; the AES core is played
// by the bench, which drives iAesDone/iCpText at chosen cycles.
module tb_aes_req_sched;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    localparam logic [127:0] K0      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0      = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1      = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_BP   = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] CT_LATE = 128'h5555aaaa5555aaaa5555aaaa5555aaaa;
    localparam logic [127:0] CT_SIM  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] CT_ABRT = 128'h11112222333344445555666677778888;

    logic [127:0] ctTab [4] = '{128'h3925841d02dc09fbdc118597196a0b32,
                                128'ha1a2a3a4a5a6a7a8a9aaabacadaeafb0,
                                128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf,
                                128'h0102030405060708090a0b0c0d0e0f10};

    aes_req_sched_if #(.NUM_REQ(2)) bus ();

    aes_req_sched #(
        .NUM_REQ (2),
        .TIMEOUT (64),
        .CNT_W   (8)
    ) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.iReqVld = 2'b00; bus.iRspRdy = 2'b00;
        bus.iAesDone = 1'b0; bus.iCpText = '0;
        bus.iReqKey = {K1, K0}; bus.iReqPText = {P1, P0};
        tick(); tick();
        rst = 1'b0;
        total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", bus.oBusy); end
        total++; if (bus.oStAes !== 1'b0) begin bad++; $display("FAIL reset_start got=%0h exp=0", bus.oStAes); end
        total++; if (bus.oRspVld !== 2'b00) begin bad++; $display("FAIL reset_rspvld got=%0h exp=0", bus.oRspVld); end
        total++; if (bus.oRspData !== '0) begin bad++; $display("FAIL reset_rspdata got=%0h exp=0", bus.oRspData); end
        total++; if (bus.oRspErr !== 1'b0) begin bad++; $display("FAIL reset_rsperr got=%0h exp=0", bus.oRspErr); end
        total++; if (bus.oAesKey !== '0) begin bad++; $display("FAIL reset_key got=%0h exp=0", bus.oAesKey); end
        total++; if (bus.oPlainText !== '0) begin bad++; $display("FAIL reset_ptext got=%0h exp=0", bus.oPlainText); end
        total++; if (bus.oReqRdy !== 2'b00) begin bad++; $display("FAIL reset_reqrdy got=%0h exp=0", bus.oReqRdy); end
        bus.iReqVld = 2'b11; #1;
        total++; if (bus.oReqRdy !== 2'b01) begin bad++; $display("FAIL reset_first_prio got=%0h exp=1", bus.oReqRdy); end
        bus.iReqVld = 2'b00;
        $display("reset: outputs idle, requester 0 has first priority");
    endtask

    task automatic test_single_job();
        bus.iReqVld = 2'b01; #1;
        total++; if (bus.oReqRdy !== 2'b01) begin bad++; $display("FAIL single_rdy got=%0h exp=1", bus.oReqRdy); end
        tick();
        bus.iReqVld = 2'b00;
        total++; if (bus.oStAes !== 1'b1) begin bad++; $display("FAIL single_start got=%0h exp=1", bus.oStAes); end
        total++; if (bus.oAesKey !== K0) begin bad++; $display("FAIL single_key got=%0h exp=%0h", bus.oAesKey, K0); end
        total++; if (bus.oPlainText !== P0) begin bad++; $display("FAIL single_ptext got=%0h exp=%0h", bus.oPlainText, P0); end
        tick();
        total++; if (bus.oStAes !== 1'b0) begin bad++; $display("FAIL single_pulse_width got=%0h exp=0", bus.oStAes); end
        total++; if (bus.oBusy !== 1'b1) begin bad++; $display("FAIL single_busy got=%0h exp=1", bus.oBusy); end
        bus.iReqKey = {K1, ~K0};
        tick(); tick();
        total++; if (bus.oAesKey !== K0) begin bad++; $display("FAIL single_key_hold got=%0h exp=%0h", bus.oAesKey, K0); end
        bus.iReqKey = {K1, K0};
        bus.iAesDone = 1'b1; bus.iCpText = CT0;
        tick();
        bus.iAesDone = 1'b0; bus.iCpText = '1;
        total++; if (bus.oRspVld !== 2'b01) begin bad++; $display("FAIL single_rspvld got=%0h exp=1", bus.oRspVld); end
        total++; if (bus.oRspData !== CT0) begin bad++; $display("FAIL single_rspdata got=%0h exp=%0h", bus.oRspData, CT0); end
        total++; if (bus.oRspErr !== 1'b0) begin bad++; $display("FAIL single_rsperr got=%0h exp=0", bus.oRspErr); end
        bus.iRspRdy = 2'b01;
        tick();
        bus.iRspRdy = 2'b00;
        total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL single_idle got=%0h exp=0", bus.oBusy); end
        $display("single: req0 ciphertext %0h", bus.oRspData);
    endtask

    task automatic test_contention();
        logic [1:0] oh;
        logic [1:0] other;
        rst = 1'b1; tick(); rst = 1'b0;
        bus.iReqVld = 2'b11;
        for (int j = 0; j < 4; j++) begin
            oh    = 2'b01 << (j % 2);
            other = ~oh;
            #1;
            total++; if (bus.oReqRdy !== oh) begin bad++; $display("FAIL cont_grant job=%0d got=%0h exp=%0h", j, bus.oReqRdy, oh); end
            tick();
            total++; if (bus.oAesKey !== ((j % 2 == 1) ? K1 : K0)) begin bad++; $display("FAIL cont_key job=%0d got=%0h", j, bus.oAesKey); end
            total++; if (bus.oReqRdy !== 2'b00) begin bad++; $display("FAIL cont_rdy_launch job=%0d got=%0h exp=0", j, bus.oReqRdy); end
            tick();
            bus.iAesDone = 1'b1; bus.iCpText = ctTab[j];
            tick();
            bus.iAesDone = 1'b0;
            total++; if (bus.oRspVld !== oh) begin bad++; $display("FAIL cont_rspvld job=%0d got=%0h exp=%0h", j, bus.oRspVld, oh); end
            total++; if (bus.oRspData !== ctTab[j]) begin bad++; $display("FAIL cont_rspdata job=%0d got=%0h exp=%0h", j, bus.oRspData, ctTab[j]); end
            bus.iRspRdy = other;
            tick();
            total++; if (bus.oRspVld !== oh) begin bad++; $display("FAIL cont_foreign_rdy job=%0d got=%0h exp=%0h", j, bus.oRspVld, oh); end
            bus.iRspRdy = oh;
            tick();
            bus.iRspRdy = 2'b00;
            $display("contention: job %0d served requester mask %0h", j, oh);
        end
        bus.iReqVld = 2'b00;
        tick();
    endtask

    task automatic test_back_to_back();
        bus.iReqVld = 2'b01;
        tick(); tick();
        bus.iAesDone = 1'b1; bus.iCpText = CT_BP;
        tick();
        bus.iAesDone = 1'b0;
        bus.iReqVld = 2'b11;
        for (int k = 0; k < 10; k++) begin
            total++; if (bus.oRspVld !== 2'b01) begin bad++; $display("FAIL bp_rspvld cyc=%0d got=%0h exp=1", k, bus.oRspVld); end
            total++; if (bus.oRspData !== CT_BP) begin bad++; $display("FAIL bp_rspdata cyc=%0d got=%0h exp=%0h", k, bus.oRspData, CT_BP); end
            total++; if (bus.oReqRdy !== 2'b00) begin bad++; $display("FAIL bp_reqrdy cyc=%0d got=%0h exp=0", k, bus.oReqRdy); end
            total++; if (bus.oStAes !== 1'b0) begin bad++; $display("FAIL bp_start cyc=%0d got=%0h exp=0", k, bus.oStAes); end
            if (k == 3) begin bus.iAesDone = 1'b1; bus.iCpText = ~CT_BP; end
            tick();
            bus.iAesDone = 1'b0;
        end
        bus.iReqVld = 2'b00;
        bus.iRspRdy = 2'b01;
        tick();
        bus.iRspRdy = 2'b00;
        total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL bp_idle got=%0h exp=0", bus.oBusy); end
        $display("backpressure: response held 10 cycles then released");
    endtask

    task automatic test_watchdog();
        int n;
        bus.iReqVld = 2'b01;
        tick();
        bus.iReqVld = 2'b00;
        total++; if (bus.oStAes !== 1'b1) begin bad++; $display("FAIL wd_start got=%0h exp=1", bus.oStAes); end
        n = 0;
        while (bus.oRspVld == 2'b00 && n < 200) begin
            tick();
            n++;
        end
        // 64 BUSY cycles follow the start-pulse cycle, so RESP is 65 cycles later
        total++; if (n != 65) begin bad++; $display("FAIL wd_latency got=%0d exp=65", n); end
        total++; if (bus.oRspErr !== 1'b1) begin bad++; $display("FAIL wd_err got=%0h exp=1", bus.oRspErr); end
        total++; if (bus.oRspData !== '0) begin bad++; $display("FAIL wd_data got=%0h exp=0", bus.oRspData); end
        total++; if (bus.oRspVld !== 2'b01) begin bad++; $display("FAIL wd_rspvld got=%0h exp=1", bus.oRspVld); end
        bus.iAesDone = 1'b1; bus.iCpText = CT_LATE;
        tick();
        bus.iAesDone = 1'b0;
        total++; if (bus.oRspErr !== 1'b1) begin bad++; $display("FAIL wd_late_err got=%0h exp=1", bus.oRspErr); end
        total++; if (bus.oRspData !== '0) begin bad++; $display("FAIL wd_late_data got=%0h exp=0", bus.oRspData); end
        bus.iRspRdy = 2'b01;
        tick();
        bus.iRspRdy = 2'b00;
        total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL wd_idle got=%0h exp=0", bus.oBusy); end
        $display("watchdog: error response after %0d cycles", n);
    endtask

    task automatic test_simul_done_timeout();
        bus.iReqVld = 2'b01;
        tick();
        bus.iReqVld = 2'b00;
        repeat (63) tick();
        total++; if (bus.oRspVld !== 2'b00) begin bad++; $display("FAIL sim_early_a got=%0h exp=0", bus.oRspVld); end
        tick();
        total++; if (bus.oRspVld !== 2'b00) begin bad++; $display("FAIL sim_early_b got=%0h exp=0", bus.oRspVld); end
        total++; if (bus.oBusy !== 1'b1) begin bad++; $display("FAIL sim_busy got=%0h exp=1", bus.oBusy); end
        bus.iAesDone = 1'b1; bus.iCpText = CT_SIM;
        tick();
        bus.iAesDone = 1'b0;
        total++; if (bus.oRspErr !== 1'b0) begin bad++; $display("FAIL sim_err got=%0h exp=0", bus.oRspErr); end
        total++; if (bus.oRspData !== CT_SIM) begin bad++; $display("FAIL sim_data got=%0h exp=%0h", bus.oRspData, CT_SIM); end
        total++; if (bus.oRspVld !== 2'b01) begin bad++; $display("FAIL sim_rspvld got=%0h exp=1", bus.oRspVld); end
        bus.iRspRdy = 2'b01;
        tick();
        bus.iRspRdy = 2'b00;
        $display("simultaneous: done beat timeout, data %0h", bus.oRspData);
    endtask

    task automatic test_reset_mid_busy();
        bus.iReqVld = 2'b01;
        tick();
        bus.iReqVld = 2'b00;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL rmb_busy got=%0h exp=0", bus.oBusy); end
        total++; if (bus.oStAes !== 1'b0) begin bad++; $display("FAIL rmb_start got=%0h exp=0", bus.oStAes); end
        total++; if (bus.oRspVld !== 2'b00) begin bad++; $display("FAIL rmb_rspvld got=%0h exp=0", bus.oRspVld); end
        total++; if (bus.oRspData !== '0) begin bad++; $display("FAIL rmb_rspdata got=%0h exp=0", bus.oRspData); end
        total++; if (bus.oAesKey !== '0) begin bad++; $display("FAIL rmb_key got=%0h exp=0", bus.oAesKey); end
        total++; if (bus.oPlainText !== '0) begin bad++; $display("FAIL rmb_ptext got=%0h exp=0", bus.oPlainText); end
        bus.iAesDone = 1'b1; bus.iCpText = CT_ABRT;
        tick();
        bus.iAesDone = 1'b0;
        total++; if (bus.oRspVld !== 2'b00) begin bad++; $display("FAIL rmb_no_rsp got=%0h exp=0", bus.oRspVld); end
        total++; if (bus.oRspData !== '0) begin bad++; $display("FAIL rmb_no_capture got=%0h exp=0", bus.oRspData); end
        bus.iReqVld = 2'b11; #1;
        total++; if (bus.oReqRdy !== 2'b01) begin bad++; $display("FAIL rmb_ptr_reset got=%0h exp=1", bus.oReqRdy); end
        tick();
        bus.iReqVld = 2'b00;
        total++; if (bus.oAesKey !== K0) begin bad++; $display("FAIL rmb_next_key got=%0h exp=%0h", bus.oAesKey, K0); end
        tick();
        bus.iAesDone = 1'b1; bus.iCpText = CT0;
        tick();
        bus.iAesDone = 1'b0;
        bus.iRspRdy = 2'b01;
        tick();
        bus.iRspRdy = 2'b00;
        total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL rmb_final_idle got=%0h exp=0", bus.oBusy); end
        $display("reset mid-busy: job aborted, requester 0 won next contention");
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_contention();
        test_back_to_back();
        test_watchdog();
        test_simul_done_timeout();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_req_sched.md
Name: aes_req_sched

Overview:
- Round-robin scheduler that shares one AES-128 encryption core among NUM_REQ requesters.
- Accepts one key/plaintext job at a time, launches the core with a one-cycle start pulse and holds its operands stable.
- Captures the ciphertext on the core's done pulse and returns it to the owning requester through a valid/ready response port.
- Sits between the system-side request masters and the AES core, and also provides a completion watchdog.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT, 64, maximum cycles in BUSY before an error response (>= 16).
- CNT_W, 8, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- iClk  in  1  clock, rising edge.
- iRst  in  1  reset; one clock, reset is synchronous and active-high.
- iReqVld  in  NUM_REQ  per-requester request valid.
- oReqRdy  out  NUM_REQ  per-requester accept; at most one bit set.
- iReqKey  in  128*NUM_REQ  flattened keys; requester i occupies [128*i+127:128*i].
- iReqPText  in  128*NUM_REQ  flattened plaintexts, same packing as iReqKey.
- oRspVld  out  NUM_REQ  one-hot response valid to the owning requester.
- iRspRdy  in  NUM_REQ  per-requester response ready.
- oRspData  out  128  ciphertext; all zeros on error.
- oRspErr  out  1  response is a watchdog timeout.
- oStAes  out  1  core start, one-cycle pulse.
- oAesKey  out  128  core key, held from LAUNCH until BUSY exits.
- oPlainText  out  128  core plaintext, held the same way.
- iAesDone  in  1  core done pulse.
- iCpText  in  128  core ciphertext, valid while iAesDone=1.
- oBusy  out  1  state != IDLE.

Behaviour:
- Reset (iRst=1 at a clock edge) gives: state IDLE, all outputs 0, RR pointer = NUM_REQ-1 (so requester 0 has first priority), watchdog 0.
  - Reset mid-operation aborts the job. No response is issued for it.
- States are IDLE, LAUNCH, BUSY, RESP.
- IDLE:
  - Grant = first i with iReqVld[i]=1, searching from (ptr+1) mod NUM_REQ with wrap-around.
  - oReqRdy = grant one-hot; it is combinational from iReqVld and only asserted in IDLE.
  - On iReqVld[g] & oReqRdy[g]: latch key, plaintext and id g; set ptr=g; go to LAUNCH.
  - With no valid request, stay in IDLE.
- LAUNCH: oStAes=1 for exactly this cycle; clear watchdog; go to BUSY.
- BUSY:
  - Watchdog increments every cycle.
  - If iAesDone=1: capture iCpText into oRspData, set oRspErr=0, go to RESP.
  - Else if watchdog == TIMEOUT-1: set oRspData=0, set oRspErr=1, go to RESP.
  - If done and timeout coincide, done wins.
- RESP:
  - oRspVld[id]=1; oRspData and oRspErr are held stable.
  - On iRspRdy[id]=1, go to IDLE. iRspRdy of other requesters is ignored.
- Latency: acceptance at edge N gives oStAes high during cycle N+1. A core done in cycle D gives oRspVld high from cycle D+1.
- Throughput: one job in flight. The earliest next acceptance is the cycle after the response handshake.
- iAesDone outside BUSY is ignored. This covers a late done following a timeout and a done during LAUNCH.
- oAesKey and oPlainText:
  - Change only on entry to LAUNCH.
  - Remain stable through BUSY.
  - Are don't-care but unchanged in RESP and IDLE.
- Fairness: a requester that holds iReqVld continuously is served within NUM_REQ jobs.
- iReqVld may drop without acceptance. No request is latched unless the handshake completes.

Decomposition:
- Shared package aes_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_LAUNCH=2'd1, ST_BUSY=2'd2, ST_RESP=2'd3;
  - AES_W=128;
  - the default TIMEOUT value.
- One sub-module, aes_rr_arb:
  - purely combinational priority rotate;
  - inputs are the request vector and the pointer; output is the one-hot grant plus the encoded index.
  - Reusable by later multi-core schedulers.

Test Plan:
- Single job: requester 0 sends key 000102030405060708090a0b0c0d0e0f and plaintext 00112233445566778899aabbccddeeff to a real core → oStAes is a single pulse one cycle after acceptance; oRspVld=2'b01; oRspData=69c4e0d86a7b0430d8cdb78070b4c55a; oRspErr=0.
- Contention: both requesters valid continuously after reset → grants alternate 0,1,0,1 over 4 jobs. Each oRspVld bit matches the granted id.
- Response backpressure: iRspRdy[0] held low for 10 cycles after done → oRspVld and oRspData stay stable for 10 cycles. oReqRdy stays 0 and no new oStAes is issued. IDLE is reached one cycle after ready rises.
- Watchdog: a stub core never asserts done, TIMEOUT=64 → oRspVld rises 64 cycles after the oStAes pulse with oRspErr=1 and oRspData=0. A stub done injected one cycle later is ignored.
- Simultaneous done and timeout: the stub asserts done on the watchdog's last BUSY cycle → oRspErr=0 and oRspData=iCpText.
- Reset mid-BUSY: iRst pulsed for 1 cycle during BUSY → next cycle all outputs are 0, oBusy=0 and the RR pointer is reset. No response is issued for the aborted job, and requester 0 wins the next contention.
